// File: rtl/sixteen_bit_adder_pkg.sv
// Shared sizing constants for the two-level carry-lookahead adder.
// The adder is built from four 4-bit lookahead groups.
package sixteen_bit_adder_pkg;

    localparam int WIDTH      = 16;
    localparam int GROUP_W    = 4;
    localparam int NUM_GROUPS = WIDTH / GROUP_W;

endpackage

// File: rtl/sixteen_bit_adder_cla4_block.sv
// 4-bit carry-lookahead group: produces its sum bits from a group carry-in,
// plus the group propagate/generate terms used by the second lookahead level.
module cla4_block
    import sixteen_bit_adder_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               ci,
    output logic [GROUP_W-1:0] sum,
    output logic               gp,
    output logic               gg
);

    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Every internal carry is a flat sum of products, so no carry ripples within the group.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign sum = p ^ c;
    assign gp  = &p;
    assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/sixteen_bit_adder.sv
// 16-bit two-level carry-lookahead adder with registered sum and carry-out.
// Operands are unregistered; the result appears one clock after sampling.
module sixteen_bit_adder #(
    parameter int WIDTH   = sixteen_bit_adder_pkg::WIDTH,
    parameter int GROUP_W = sixteen_bit_adder_pkg::GROUP_W
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    input  logic             cin,
    input  logic             clk,
    input  logic             rst_n
);
    import sixteen_bit_adder_pkg::NUM_GROUPS;

    logic [NUM_GROUPS-1:0] grpP;
    logic [NUM_GROUPS-1:0] grpG;
    logic [NUM_GROUPS:0]   grpC;
    logic [WIDTH-1:0]      sum;

    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             cout_d;
    logic             cout_q;

    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
        cla4_block u_cla4 (
            .a   (x[gi*GROUP_W +: GROUP_W]),
            .b   (y[gi*GROUP_W +: GROUP_W]),
            .ci  (grpC[gi]),
            .sum (sum[gi*GROUP_W +: GROUP_W]),
            .gp  (grpP[gi]),
            .gg  (grpG[gi])
        );
    end

    // Second lookahead level: the group carries use the same equations as inside a group.
    assign grpC[0] = cin;
    assign grpC[1] = grpG[0] | (grpP[0] & cin);
    assign grpC[2] = grpG[1] | (grpP[1] & grpG[0]) | (grpP[1] & grpP[0] & cin);
    assign grpC[3] = grpG[2] | (grpP[2] & grpG[1]) | (grpP[2] & grpP[1] & grpG[0])
                   | (grpP[2] & grpP[1] & grpP[0] & cin);
    assign grpC[4] = grpG[3] | (grpP[3] & grpG[2]) | (grpP[3] & grpP[2] & grpG[1])
                   | (grpP[3] & grpP[2] & grpP[1] & grpG[0])
                   | (grpP[3] & grpP[2] & grpP[1] & grpP[0] & cin);

    always_comb begin
        s_d    = sum;
        cout_d = grpC[NUM_GROUPS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_sixteen_bit_adder.sv
// Self-checking bench for sixteen_bit_adder: reset behaviour, directed
// boundary vectors, mid-stream reset and back-to-back random traffic.
module tb_sixteen_bit_adder;

    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] s;
    logic        cout;
    logic        cin;
    logic        clk;
    logic        rst_n;

    int checks   = 0;
    int failures = 0;

    sixteen_bit_adder dut (
        .x     (x),
        .y     (y),
        .s     (s),
        .cout  (cout),
        .cin   (cin),
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        x     = 16'h1234;
        y     = 16'h4321;
        cin   = 1'b1;
        #2;
        checks++;
        if (s !== 16'h0000 || cout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_async: s=%h cout=%b, required s=0000 cout=0", s, cout);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s !== 16'h0000 || cout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_hold: s=%h cout=%b, required s=0000 cout=0", s, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        x     = 16'h0001;
        y     = 16'h0002;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (s !== 16'h0003 || cout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_first_edge: s=%h cout=%b, required s=0003 cout=0", s, cout);
        end
    endtask

    task automatic test_directed();
        logic [15:0] vx [8];
        logic [15:0] vy [8];
        logic        vc [8];
        logic [15:0] es [8];
        logic        ec [8];
        vx = '{16'h0001, 16'hFFFF, 16'h8000, 16'h0FFF, 16'hFFFF, 16'h1234, 16'h00FF, 16'h7FFF};
        vy = '{16'h0004, 16'h0000, 16'h8000, 16'h0001, 16'hFFFF, 16'h4321, 16'h0001, 16'h0000};
        vc = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
        es = '{16'h0005, 16'h0000, 16'h0000, 16'h1000, 16'hFFFF, 16'h5555, 16'h0100, 16'h8000};
        ec = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            x   = vx[i];
            y   = vy[i];
            cin = vc[i];
            @(posedge clk);
            #1;
            checks++;
            if (s !== es[i] || cout !== ec[i]) begin
                failures++;
                $display("[TB] FAIL directed_%0d: s=%h cout=%b, required s=%h cout=%b",
                         i, s, cout, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        x   = 16'h1111;
        y   = 16'h2222;
        cin = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (s !== 16'h3333 || cout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_pre: s=%h cout=%b, required s=3333 cout=0", s, cout);
        end
        x   = 16'hF0F0;
        y   = 16'h1F1F;
        cin = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (s !== 16'h0000 || cout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_immediate: s=%h cout=%b, required s=0000 cout=0", s, cout);
        end
        @(posedge clk);
        #1;
        checks++;
        if (s !== 16'h0000 || cout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_discard: s=%h cout=%b, required s=0000 cout=0", s, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        x     = 16'h0003;
        y     = 16'h0004;
        cin   = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s !== 16'h0008 || cout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_release: s=%h cout=%b, required s=0008 cout=0", s, cout);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] expected;
        int          localFails;
        localFails = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            x        = 16'($urandom);
            y        = 16'($urandom);
            cin      = 1'($urandom_range(0, 1));
            expected = {1'b0, x} + {1'b0, y} + {16'h0000, cin};
            @(posedge clk);
            #1;
            checks++;
            if ({cout, s} !== expected) begin
                failures++;
                localFails++;
                if (localFails <= 10)
                    $display("[TB] FAIL b2b_%0d: x=%h y=%h cin=%b got cout=%b s=%h, required cout=%b s=%h",
                             i, x, y, cin, cout, s, expected[16], expected[15:0]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        x     = '0;
        y     = '0;
        cin   = 1'b0;
        test_reset();
        test_directed();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sixteen_bit_adder.md
SIXTEEN_BIT_ADDER -- requirements
Module: sixteen_bit_adder

Interface
- REQ-001 Parameter WIDTH, default 16: operand and sum width; only 16 is supported.
- REQ-002 Parameter GROUP_W, default 4: bits per lookahead group; only 4 is supported, giving 4 groups.
- REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
- REQ-004 Port rst_n, input, 1: reset is asynchronous and active-low.
- REQ-005 Port x, input, 16: operand A, unsigned.
- REQ-006 Port y, input, 16: operand B, unsigned.
- REQ-007 Port s, output, 16: registered sum.
- REQ-008 Port cout, output, 1: registered carry out of bit 15.
- REQ-009 Port cin, input, 1: carry into bit 0.
- REQ-010 Positional port order SHALL be x, y, s, cout, cin, clk, rst_n.

Function
- REQ-011 The block SHALL compute {cout, s} = x + y + cin, modulo 2^17, with no truncation of the carry.
- REQ-012 Per bit i: p[i] = x[i] XOR y[i]; g[i] = x[i] AND y[i]; s[i] = p[i] XOR c[i].
- REQ-013 Each 4-bit group SHALL produce internal carries by full lookahead from p, g and the group carry-in, with no ripple inside the group.
- REQ-014 Each group SHALL produce group propagate P = p3&p2&p1&p0.
- REQ-015 Each group SHALL produce group generate G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- REQ-016 Group carry-ins C4, C8, C12 and cout SHALL come from a second-level lookahead unit driven by group P/G and cin, using the same equations one level up.
- REQ-017 The adder core SHALL be purely combinational.
- REQ-018 Latency SHALL be 1 cycle: x, y, cin sampled at rising edge N appear on s/cout immediately after edge N.
- REQ-019 Inputs SHALL NOT be registered; outputs are.
- REQ-020 A new operation SHALL be accepted every cycle; there is no handshake and no stall.
- REQ-021 Boundary: a carry propagating through all 16 bits (e.g. 0xFFFF + 0 + 1) SHALL resolve within one cycle and yield s=0x0000, cout=1.
- REQ-022 Boundary: cin=1 with x=y=0xFFFF SHALL yield s=0xFFFF, cout=1.
- REQ-023 X/Z on inputs need not be handled; behaviour is defined for 0/1 inputs only.

Reset
- REQ-024 When rst_n=0, s SHALL become 0x0000 and cout 0 immediately, regardless of clk.
- REQ-025 While rst_n=0, outputs SHALL hold zero and input sampling is ignored.
- REQ-026 On rst_n rising, the first sampling edge SHALL be the next rising clk; there is no additional warm-up cycle.
- REQ-027 Reset asserted mid-stream SHALL discard the in-flight result.

Structure
- REQ-028 A shared package SHALL hold WIDTH=16, GROUP_W=4 and NUM_GROUPS=4.
- REQ-029 One sub-module, cla4_block, SHALL be instantiated 4 times.
  - inputs: a[3:0], b[3:0], ci
  - outputs: sum[3:0], gp, gg
- REQ-030 The second-level lookahead and the output register SHALL reside in sixteen_bit_adder.

Verification
- REQ-031 x=0x0001, y=0x0004, cin=0 -> s=0x0005, cout=0 one cycle later.
- REQ-032 x=0xFFFF, y=0x0000, cin=1 -> s=0x0000, cout=1 (full propagate chain).
- REQ-033 x=0x8000, y=0x8000, cin=0 -> s=0x0000, cout=1.
- REQ-034 x=0x0FFF, y=0x0001, cin=0 -> s=0x1000, cout=0 (cross-group carry).
- REQ-035 Assert rst_n=0 between clk edges with a pending result -> s=0x0000, cout=0 immediately; after release, the next edge produces the new sum.
- REQ-036 Back-to-back random stimulus, ≥10k vectors including cin toggling -> every output matches x+y+cin of the prior cycle.
